// File: rtl/pc_sequencer.sv
// Fetch PC controller: drives the ROM address, registers the returned word toward decode with valid/ready.
// Optional PC_SEQ_OVF_FAULT_EN: a capture at the top address delivers that word and then enters a sticky FAULT state.
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HALT_OP  = 6'b111111
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  pc,
  input  logic [INS_W-1:0] ins,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1
`ifdef PC_SEQ_OVF_FAULT_EN
    ,S_FAULT = 2'd2
`endif
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic             out_valid_q;
  logic [INS_W-1:0] out_ins_q;
  logic [PC_W-1:0]  out_pc_q;
  logic             halted_q;

  logic take;
  logic cap;
  logic redirect_ok;
  logic is_halt_op;

  assign take        = out_valid_q & out_ready;
  assign cap         = (state_q == S_RUN) & (~out_valid_q | out_ready) & ~redirect;
  assign is_halt_op  = (ins[INS_W-1 -: 6] == HALT_OP);
  assign pc_d        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef PC_SEQ_OVF_FAULT_EN
  logic fault_q;
  logic at_top;
  assign at_top      = &pc_q;
  // FAULT is terminal apart from reset, so redirects are dropped there.
  assign redirect_ok = redirect & (state_q != S_FAULT);
  assign fault       = fault_q;
`else
  assign redirect_ok = redirect;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_ins_q   <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
`ifdef PC_SEQ_OVF_FAULT_EN
      fault_q     <= 1'b0;
`endif
    end else if (redirect_ok) begin
      // Flush: any word presented this cycle is either taken now or discarded.
      state_q     <= S_RUN;
      pc_q        <= redirect_pc;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else if (cap) begin
      out_ins_q   <= ins;
      out_pc_q    <= pc_q;
      out_valid_q <= 1'b1;
      pc_q        <= pc_d;
`ifdef PC_SEQ_OVF_FAULT_EN
      if (at_top) begin
        state_q <= S_FAULT;
        fault_q <= 1'b1;
      end else if (is_halt_op) begin
        state_q  <= S_HALT;
        halted_q <= 1'b1;
      end
`else
      if (is_halt_op) begin
        state_q  <= S_HALT;
        halted_q <= 1'b1;
      end
`endif
    end else if (take) begin
      out_valid_q <= 1'b0;
    end
  end

  assign pc        = pc_q;
  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_pc    = out_pc_q;
  assign halted    = halted_q;

endmodule
